led_seq_ctrl: RTL
=================

// Module: led_seq_ctrl
// PURPOSE
//   Sequencer for the LED shift datapath: prescales clock into a step tick and
//   runs an FSM that drives the LED pattern (rotate left/right, flash, bounce).
//   Replaces the fixed count->shiftreg chain with switch-selected speed and mode.
//   Sits between board switches and the o_led / colour-mux outputs of top.
// PARAMETERS
//   NB_LEDS    4           LED pattern width (>=2)
//   NB_COUNTER 32          prescaler counter width
//   LIMIT0     2**26-1     tick period-1 for i_speed=0 (slowest)
//   LIMIT1     2**25-1     tick period-1 for i_speed=1
//   LIMIT2     2**24-1     tick period-1 for i_speed=2
//   LIMIT3     2**23-1     tick period-1 for i_speed=3 (fastest)
// PORTS
//   clock     in   1        system clock, all logic on rising edge
//   i_reset   in   1        asynchronous reset, active-low
//   i_enable  in   1        1: sequencer runs; 0: pause (pattern frozen)
//   i_speed   in   2        prescaler limit select (LIMIT0..LIMIT3)
//   i_mode    in   2        00 rot-left, 01 rot-right, 10 flash, 11 bounce
//   o_led     out  NB_LEDS  current LED pattern (registered)
//   o_tick    out  1        1-cycle pulse on every pattern step
//   o_state   out  3        FSM state encoding (debug)
// BEHAVIOUR
//   Reset (i_reset=0, async): counter=0, o_led={{NB_LEDS-1{0}},1}, o_tick=0,
//     state=IDLE(000), bounce direction=left.
//   Prescaler: runs only when i_enable=1; limit L=LIMIT[i_speed] sampled every
//     cycle. If counter>=L: counter<=0, tick=1; else counter<=counter+1, tick=0.
//     Comparison is >= so a speed change to a smaller limit ticks next cycle.
//     i_enable=0: counter held (not cleared), tick=0.
//   o_tick registered: asserted the same cycle o_led takes its new value.
//   FSM states: IDLE 000, ROT_L 001, ROT_R 010, FLASH 011, BOUNCE 100.
//     IDLE -> mode state selected by i_mode on first tick after i_enable=1.
//     Any run state -> new mode state only on a tick (mode changes mid-period
//     are deferred, no glitch). i_enable=0 -> stays in current state, pattern held.
//   Pattern update on tick (in the state being entered/held):
//     ROT_L : o_led <= {o_led[N-2:0], o_led[N-1]}
//     ROT_R : o_led <= {o_led[0], o_led[N-1:1]}
//     FLASH : o_led <= ~o_led   (entering FLASH from other state: load all-ones)
//     BOUNCE: one-hot walk; dir left shifts left, at bit N-1 dir flips to right;
//             at bit 0 flips to left; the end bit is shown for exactly one tick.
//   Entering ROT_L/ROT_R/BOUNCE from FLASH (pattern not one-hot): load 1 (LSB).
//   Reset mid-operation: immediate return to reset values, no pending tick.
// CONFIGURATION
//   LED_SEQ_BOUNCE_EN defined: BOUNCE state and direction register present.
//   Not defined: i_mode=11 behaves as ROT_L (state 001); state 100 unreachable.
// TESTING (benches override LIMIT0..3 = 3,2,1,0)
//   Reset low 3 cycles, release, i_enable=0 -> o_led=0001, o_tick=0, o_state=000.
//   i_enable=1, i_speed=0, i_mode=00 -> tick every 4 clocks; o_led 0001,0010,
//     0100,1000,0001.
//   i_speed=3, i_mode=01, enable -> o_led 1000 after 1st tick, step every clock;
//     i_enable=0 mid-run -> o_led frozen, o_tick=0 until re-enabled.
//   Mode 00->10 changed 2 clocks before tick at speed 0 -> o_led unchanged until
//     tick, then 1111, 0000, 1111 every 4 clocks; back to 00 -> 0001.
//   LED_SEQ_BOUNCE_EN, i_mode=11, speed 3 -> 0001,0010,0100,1000,0100,0010,0001,
//     0010; without macro same stimulus -> ROT_L sequence, o_state=001.
//   Assert i_reset=0 between clock edges while running -> o_led=0001, o_state=000
//     immediately (async), counter restarts from 0 after release.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: clock prescaler producing a step tick, plus a mode FSM
// driving rotate-left/right, flash and (with LED_SEQ_BOUNCE_EN defined) bounce patterns.
module led_seq_ctrl #(
  parameter int unsigned NB_LEDS    = 4,
  parameter int unsigned NB_COUNTER = 32,
  parameter int unsigned LIMIT0     = 2**26-1,
  parameter int unsigned LIMIT1     = 2**25-1,
  parameter int unsigned LIMIT2     = 2**24-1,
  parameter int unsigned LIMIT3     = 2**23-1
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [1:0]         i_speed,
  input  logic [1:0]         i_mode,
  output logic [NB_LEDS-1:0] o_led,
  output logic               o_tick,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    ROT_L  = 3'b001,
    ROT_R  = 3'b010,
    FLASH  = 3'b011,
    BOUNCE = 3'b100
  } state_t;

  state_t                  state, state_nxt, mode_state;
  logic [NB_COUNTER-1:0]   counter, counter_nxt, limit;
  logic [NB_LEDS-1:0]      led_nxt;
  logic                    tick_now;
`ifdef LED_SEQ_BOUNCE_EN
  logic                    dir_right, dir_right_nxt, walk_right;
`endif

  always_comb begin
    limit = '0;
    case (i_speed)
      2'd0:    limit = NB_COUNTER'(LIMIT0);
      2'd1:    limit = NB_COUNTER'(LIMIT1);
      2'd2:    limit = NB_COUNTER'(LIMIT2);
      default: limit = NB_COUNTER'(LIMIT3);
    endcase
  end

  always_comb begin
    mode_state = ROT_L;
    case (i_mode)
      2'b00:   mode_state = ROT_L;
      2'b01:   mode_state = ROT_R;
      2'b10:   mode_state = FLASH;
`ifdef LED_SEQ_BOUNCE_EN
      default: mode_state = BOUNCE;
`else
      default: mode_state = ROT_L;
`endif
    endcase
  end

  always_comb begin
    tick_now    = 1'b0;
    counter_nxt = counter;
    state_nxt   = state;
    led_nxt     = o_led;
`ifdef LED_SEQ_BOUNCE_EN
    dir_right_nxt = dir_right;
    walk_right    = 1'b0;
`endif
    if (i_enable) begin
      if (counter >= limit) begin
        tick_now    = 1'b1;
        counter_nxt = '0;
      end else begin
        counter_nxt = counter + NB_COUNTER'(1);
      end
    end

    // Mode is only sampled on a tick, so mid-period mode changes are deferred.
    if (tick_now) begin
      state_nxt = mode_state;
      case (mode_state)
        ROT_L: led_nxt = (state == FLASH) ? NB_LEDS'(1)
                                          : {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
        ROT_R: led_nxt = (state == FLASH) ? NB_LEDS'(1)
                                          : {o_led[0], o_led[NB_LEDS-1:1]};
        FLASH: led_nxt = (state == FLASH) ? ~o_led : '1;
`ifdef LED_SEQ_BOUNCE_EN
        BOUNCE: begin
          if (state == FLASH) begin
            led_nxt       = NB_LEDS'(1);
            dir_right_nxt = 1'b0;
          end else begin
            // Direction restarts leftwards on entry; the end bits force a turn.
            walk_right = (state == BOUNCE) ? dir_right : 1'b0;
            if (o_led[NB_LEDS-1])
              walk_right = 1'b1;
            else if (o_led[0])
              walk_right = 1'b0;
            dir_right_nxt = walk_right;
            led_nxt = walk_right ? {1'b0, o_led[NB_LEDS-1:1]}
                                 : {o_led[NB_LEDS-2:0], 1'b0};
          end
        end
`endif
        default: led_nxt = o_led;
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      counter <= '0;
      o_led   <= NB_LEDS'(1);
      o_tick  <= 1'b0;
      state   <= IDLE;
`ifdef LED_SEQ_BOUNCE_EN
      dir_right <= 1'b0;
`endif
    end else begin
      counter <= counter_nxt;
      o_led   <= led_nxt;
      o_tick  <= tick_now;
      state   <= state_nxt;
`ifdef LED_SEQ_BOUNCE_EN
      dir_right <= dir_right_nxt;
`endif
    end
  end

  assign o_state = state;

endmodule
